// File: rtl/mux_sel_sequencer_if.sv
// Byte handshake into the mux select sequencer.
// master drives the byte, slave reports readiness.
interface mux_sel_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Byte serializer driving an 8:1 bit mux select at DIV clocks per bit.
// Define MUX_SEL_SEQUENCER_MSB_FIRST_EN to emit bit 7 first.
module mux_sel_sequencer #(
    parameter int DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_sel_sequencer_if.slave  in_bus,
    input  logic                abort,
    output logic [7:0]          d_hold,
    output logic [2:0]          sel,
    output logic                bit_valid,
    output logic                frame_start,
    output logic                frame_end,
    output logic                busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

`ifdef MUX_SEL_SEQUENCER_MSB_FIRST_EN
    localparam logic [2:0] FIRST = 3'd7;
    localparam logic [2:0] LAST  = 3'd0;
`else
    localparam logic [2:0] FIRST = 3'd0;
    localparam logic [2:0] LAST  = 3'd7;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          xfer;
    logic          strobe;
    logic          wrap;

    function automatic logic [2:0] next_idx(input logic [2:0] s);
`ifdef MUX_SEL_SEQUENCER_MSB_FIRST_EN
        return s - 3'd1;
`else
        return s + 3'd1;
`endif
    endfunction

    assign xfer = in_bus.in_valid && (state == IDLE);
    assign wrap = (cnt == CMAX);
    // abort masks the strobe in the very cycle it is raised
    assign strobe = (state == SHIFT) && wrap && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (abort || (strobe && sel == LAST)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_bus.in_ready = 1'b0;
        bit_valid       = 1'b0;
        frame_start     = 1'b0;
        frame_end       = 1'b0;
        unique case (state)
            IDLE: begin
                in_bus.in_ready = 1'b1;
            end
            SHIFT: begin
                bit_valid   = strobe;
                frame_start = strobe && (sel == FIRST);
                frame_end   = strobe && (sel == LAST);
            end
            default: begin
                in_bus.in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_hold <= 8'h00;
            sel    <= FIRST;
            cnt    <= '0;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        d_hold <= in_bus.in_data;
                        sel    <= FIRST;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        sel  <= FIRST;
                        cnt  <= '0;
                        busy <= 1'b0;
                    end else begin
                        cnt <= wrap ? '0 : cnt + 1'b1;
                        if (wrap) begin
                            if (sel == LAST) begin
                                sel  <= FIRST;
                                busy <= 1'b0;
                            end else begin
                                sel <= next_idx(sel);
                            end
                        end
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: four instances at DIV 4,1,2,3
// checked each cycle against a frame-offset model.
`timescale 1ns/1ps
module tb_mux_sel_sequencer;

    localparam int N = 4;

`ifdef MUX_SEL_SEQUENCER_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif
    localparam logic [2:0] FIRST = MSB ? 3'd7 : 3'd0;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 2 : 3;
    endfunction

    // mux index emitted as the k-th bit of a frame
    function automatic logic [2:0] idx(input int k);
        return MSB ? 3'(7 - k) : 3'(k);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst_n;
    logic [N-1:0] in_valid;
    logic [N-1:0] abort;
    logic [N-1:0] in_ready;
    logic [N-1:0] bit_valid;
    logic [N-1:0] frame_start;
    logic [N-1:0] frame_end;
    logic [N-1:0] busy;
    logic [7:0]   in_data [N];
    logic [7:0]   d_hold  [N];
    logic [2:0]   sel     [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mux_sel_sequencer_if bus ();
        assign bus.in_valid = in_valid[g];
        assign bus.in_data  = in_data[g];
        assign in_ready[g]  = bus.in_ready;

        mux_sel_sequencer #(.DIV(div_of(g))) u_dut (
            .clk         (clk),
            .rst_n       (rst_n[g]),
            .in_bus      (bus),
            .abort       (abort[g]),
            .d_hold      (d_hold[g]),
            .sel         (sel[g]),
            .bit_valid   (bit_valid[g]),
            .frame_start (frame_start[g]),
            .frame_end   (frame_end[g]),
            .busy        (busy[g])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input int i, input string nm,
                       input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL inst%0d %s t=%0t got=%0h want=%0h",
                     i, nm, $time, got, exp);
        end
    endtask

    // model: frame offset n counts cycles since the accepting edge
    int         cyc;
    bit         m_act  [N];
    int         m_n    [N];
    logic [7:0] m_hold [N];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (!rst_n[i]) begin
                m_act[i]  <= 1'b0;
                m_hold[i] <= 8'h00;
            end else if (!m_act[i]) begin
                if (in_valid[i]) begin
                    m_act[i]  <= 1'b1;
                    m_n[i]    <= 1;
                    m_hold[i] <= in_data[i];
                end
            end else if (abort[i] || m_n[i] == 8 * div_of(i)) begin
                m_act[i] <= 1'b0;
            end else begin
                m_n[i] <= m_n[i] + 1;
            end
        end
    end

    logic [63:0] seq [N];
    int          nbv [N];
    int          nfe [N];
    logic [2:0]  e_sel;
    logic [7:0]  e_hold;
    logic        e_busy;
    logic        e_bv;
    logic        e_fs;
    logic        e_fe;
    int          k;

    initial begin
        for (int i = 0; i < N; i++) begin
            seq[i] = '0;
            nbv[i] = 0;
            nfe[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                e_hold = rst_n[i] ? m_hold[i] : 8'h00;
                e_busy = 1'b0;
                e_sel  = idx(0);
                e_bv   = 1'b0;
                e_fs   = 1'b0;
                e_fe   = 1'b0;
                if (rst_n[i] && m_act[i]) begin
                    k      = (m_n[i] - 1) / div_of(i);
                    e_busy = 1'b1;
                    e_sel  = idx(k);
                    e_bv   = (m_n[i] % div_of(i) == 0) && !abort[i];
                    e_fs   = e_bv && (k == 0);
                    e_fe   = e_bv && (k == 7);
                end
                chk(i, "busy", 16'(busy[i]), 16'(e_busy));
                chk(i, "in_ready", 16'(in_ready[i]), 16'(!e_busy));
                chk(i, "sel", 16'(sel[i]), 16'(e_sel));
                chk(i, "d_hold", 16'(d_hold[i]), 16'(e_hold));
                chk(i, "bit_valid", 16'(bit_valid[i]), 16'(e_bv));
                chk(i, "frame_start", 16'(frame_start[i]), 16'(e_fs));
                chk(i, "frame_end", 16'(frame_end[i]), 16'(e_fe));
                if (e_bv) begin
                    chk(i, "y", 16'(d_hold[i][sel[i]]), 16'(e_hold[e_sel]));
                end
                if (bit_valid[i]) begin
                    seq[i] = {seq[i][62:0], d_hold[i][sel[i]]};
                    nbv[i]++;
                    if (frame_end[i]) begin
                        nfe[i]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int snap_bv;
    int snap_fe;

    initial begin
        cyc      = 0;
        rst_n    = '0;
        in_valid = '0;
        abort    = '0;
        for (int i = 0; i < N; i++) begin
            in_data[i] = 8'h00;
            m_act[i]   = 1'b0;
            m_hold[i]  = 8'h00;
        end
        repeat (2) tick();
        rst_n = '1;
        for (int i = 0; i < N; i++) begin
            chk(i, "rst_sel", 16'(sel[i]), 16'(FIRST));
            chk(i, "rst_hold", 16'(d_hold[i]), 16'h00);
            chk(i, "rst_ready", 16'(in_ready[i]), 16'h1);
        end

        // basic frame, DIV=4, with input toggling during SHIFT
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hA5;
        tick();
        in_valid[0] = 1'b0;
        in_data[0]  = 8'h5A;
        repeat (2) tick();
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h3C;
        tick();
        chk(0, "t4_bv", 16'(bit_valid[0]), 16'h1);
        chk(0, "t4_fs", 16'(frame_start[0]), 16'h1);
        chk(0, "t4_sel", 16'(sel[0]), 16'(idx(0)));
        in_valid[0] = 1'b0;
        repeat (28) tick();
        chk(0, "t32_fe", 16'(frame_end[0]), 16'h1);
        chk(0, "t32_sel", 16'(sel[0]), 16'(idx(7)));
        chk(0, "t32_hold", 16'(d_hold[0]), 16'hA5);
        tick();
        chk(0, "t33_ready", 16'(in_ready[0]), 16'h1);
        chk(0, "a5_seq", 16'(seq[0][7:0]), 16'hA5);

        // back-to-back, DIV=1
        snap_bv     = nbv[1];
        in_valid[1] = 1'b1;
        in_data[1]  = 8'hFF;
        tick();
        chk(1, "b2b_bv1", 16'(bit_valid[1]), 16'h1);
        in_data[1] = 8'h00;
        repeat (8) tick();
        chk(1, "b2b_gap_ready", 16'(in_ready[1]), 16'h1);
        chk(1, "b2b_gap_bv", 16'(bit_valid[1]), 16'h0);
        tick();
        in_valid[1] = 1'b0;
        chk(1, "b2b_bv2", 16'(bit_valid[1]), 16'h1);
        repeat (10) tick();
        chk(1, "b2b_seq", seq[1][15:0], 16'hFF00);
        chk(1, "b2b_nbv", 16'(nbv[1] - snap_bv), 16'd16);

        // bit order, DIV=1, byte 8'h01
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h01;
        tick();
        in_valid[1] = 1'b0;
        repeat (10) tick();
        chk(1, "order_seq", 16'(seq[1][7:0]), MSB ? 16'h01 : 16'h80);
        chk(1, "order_idle_sel", 16'(sel[1]), 16'(FIRST));

        // abort on the third strobe, DIV=2
        snap_bv     = nbv[2];
        snap_fe     = nfe[2];
        in_valid[2] = 1'b1;
        in_data[2]  = 8'h3C;
        tick();
        in_valid[2] = 1'b0;
        repeat (5) tick();
        chk(2, "ab_sel", 16'(sel[2]), MSB ? 16'd5 : 16'd2);
        abort[2] = 1'b1;
        #1;
        chk(2, "ab_bv", 16'(bit_valid[2]), 16'h0);
        tick();
        abort[2] = 1'b0;
        chk(2, "ab_busy", 16'(busy[2]), 16'h0);
        chk(2, "ab_ready", 16'(in_ready[2]), 16'h1);
        chk(2, "ab_sel0", 16'(sel[2]), 16'(FIRST));
        repeat (4) tick();
        chk(2, "ab_nbv", 16'(nbv[2] - snap_bv), 16'd2);
        chk(2, "ab_nfe", 16'(nfe[2] - snap_fe), 16'd0);
        // abort while idle does not block a transfer
        abort[2]    = 1'b1;
        in_valid[2] = 1'b1;
        in_data[2]  = 8'hC3;
        tick();
        abort[2]    = 1'b0;
        in_valid[2] = 1'b0;
        chk(2, "idle_ab_busy", 16'(busy[2]), 16'h1);
        chk(2, "idle_ab_hold", 16'(d_hold[2]), 16'hC3);
        repeat (20) tick();
        chk(2, "idle_ab_seq", 16'(seq[2][7:0]), 16'hC3);

        // asynchronous reset mid-frame, DIV=3
        in_valid[3] = 1'b1;
        in_data[3]  = 8'h5A;
        tick();
        in_valid[3] = 1'b0;
        repeat (10) tick();
        #1;
        rst_n[3] = 1'b0;
        #1;
        chk(3, "mr_busy", 16'(busy[3]), 16'h0);
        chk(3, "mr_ready", 16'(in_ready[3]), 16'h1);
        chk(3, "mr_hold", 16'(d_hold[3]), 16'h00);
        chk(3, "mr_sel", 16'(sel[3]), 16'(FIRST));
        chk(3, "mr_bv", 16'(bit_valid[3]), 16'h0);
        snap_fe = nfe[3];
        repeat (2) tick();
        rst_n[3] = 1'b1;
        tick();
        in_valid[3] = 1'b1;
        in_data[3]  = 8'h81;
        tick();
        in_valid[3] = 1'b0;
        repeat (26) tick();
        chk(3, "mr_seq", 16'(seq[3][7:0]), 16'h81);
        chk(3, "mr_nfe", 16'(nfe[3] - snap_fe), 16'd1);
        chk(3, "mr_ready2", 16'(in_ready[3]), 16'h1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
